cache_refill_arbiter: RTL
=========================

CACHE_REFILL_ARBITER -- requirements
Module: cache_refill_arbiter

Interface
REQ-001 ADDR_WIDTH, 32, requester/AXI address width.
REQ-002 CACHELINE_WIDTH, 128, refill line width; BEATS = CACHELINE_WIDTH/AXI_DATA_WIDTH.
REQ-003 AXI_DATA_WIDTH, 32, AXI R beat width; CACHELINE_WIDTH SHALL be an integer multiple of it.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  reset; one clock, reset asynchronous active-low.
REQ-006 rreq_i  input  2  per-port refill request (port 0 icache, port 1 dcache); held high until that port's rvalid_o.
REQ-007 addr_i  input  2 x ADDR_WIDTH  per-port miss address.
REQ-008 rdy_o  output  2  one-cycle pulse: this port's AR handshake completed.
REQ-009 rvalid_o  output  2  one-cycle pulse: full line valid on rdata_o.
REQ-010 rdata_o  output  CACHELINE_WIDTH  assembled line, shared by both ports.
REQ-011 araddr_o  output  ADDR_WIDTH  AR address.
REQ-012 arlen_o  output  8  constant BEATS-1.
REQ-013 arsize_o  output  3  constant log2(AXI_DATA_WIDTH/8).
REQ-014 arburst_o  output  2  constant 2'b01 (INCR).
REQ-015 arvalid_o  output  1  AR valid.
REQ-016 arready_i  input  1  AR ready.
REQ-017 rdata_i  input  AXI_DATA_WIDTH  R beat data.
REQ-018 rvalid_i  input  1  R valid.
REQ-019 rlast_i  input  1  R last beat.
REQ-020 rready_o  output  1  R ready.

Function
REQ-021 FSM states IDLE, AR, R, RESP; one transaction outstanding at most.
REQ-022 IDLE: if any rreq_i high, latch winner index and line-aligned address {addr_i[winner][ADDR_WIDTH-1:4], 4'b0}, go AR next cycle.
REQ-023 Arbitration when both request: winner = port not granted last; pointer updates only on grant.
REQ-024 AR: arvalid_o=1, araddr_o=latched address, held stable until arready_i; on handshake pulse rdy_o[winner] same cycle, go R.
REQ-025 R: rready_o=1; each rvalid_i beat written to line slice [beat_cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH], beat_cnt increments (first beat = lowest slice).
REQ-026 Completion on beat with beat_cnt==BEATS-1; rlast_i not used for sequencing; go RESP, beat_cnt clears to 0.
REQ-027 RESP: rvalid_o[winner]=1 for exactly one cycle with rdata_o = full line, then IDLE; latency = 1 cycle after final R beat.
REQ-028 rvalid_o[winner] SHALL be suppressed in RESP if rreq_i[winner] is low (requester abandoned); AXI beats still drained.
REQ-029 rdata_o SHALL hold last assembled line outside RESP; rvalid_o/rdy_o never high for the non-winner port.
REQ-030 Back-to-back: a request pending in RESP is arbitrated in the following IDLE cycle (min 4 cycles between AR handshakes).
REQ-031 Address changes on addr_i after latch SHALL NOT affect araddr_o.

Reset
REQ-032 rst_n low immediately forces IDLE, arvalid_o=0, rready_o=0, rdy_o=0, rvalid_o=0, rdata_o=0, beat_cnt=0, pointer favouring port 0; AR constants unaffected.
REQ-033 Reset mid-transaction abandons it; no rvalid_o pulse for it after release.

Configuration
REQ-034 Macro REFILL_ARB_DCACHE_PRIO_EN defined: fixed priority, port 1 always wins simultaneous requests, pointer unused.
REQ-035 Macro undefined: round-robin per REQ-023.

Verification
REQ-036 Port 0 rreq, addr 0x1C00_0034, arready immediate, beats 0x11,0x22,0x33,0x44 -> araddr 0x1C00_0030, arlen 3, rdy_o[0] pulse, rvalid_o[0] pulse with line 0x00000044_00000033_00000022_00000011.
REQ-037 Both ports request from reset, three serial refills -> grants 0,1,0 (macro undefined); 1,1,1 with macro defined and both held.
REQ-038 arready_i low 5 cycles -> arvalid_o and araddr_o stable 6 cycles, rdy_o pulses once.
REQ-039 rvalid_i gaps between beats, rlast_i driven early on beat 2 -> line still completes on 4th beat, correct data.
REQ-040 rreq_i[0] dropped during R -> beats drained, rvalid_o[0] stays 0, FSM returns IDLE.
REQ-041 rst_n asserted during R beat 2 -> outputs zero same cycle; new request after release completes normally.

Source files
------------

// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter: arbitrates icache/dcache line refills onto one AXI read channel
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   rreq_i[1:0]          refill request per port (0 = icache, 1 = dcache)
//   addr_i[1:0]          miss address per port
//   rdy_o[1:0]           one-cycle pulse when that port's AR handshake completes
//   rvalid_o[1:0]        one-cycle pulse when the assembled line is on rdata_o
//   rdata_o              assembled cache line, shared by both ports
//   ar*_o, arready_i     AXI read-address channel (INCR burst of BEATS beats)
//   rdata_i, rvalid_i,
//   rlast_i, rready_o    AXI read-data channel
//
// Build option
//   REFILL_ARB_DCACHE_PRIO_EN  defined: port 1 wins simultaneous requests;
//                              undefined: round-robin between the ports.
module cache_refill_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int CACHELINE_WIDTH = 128,
    parameter int AXI_DATA_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [1:0]                      rreq_i,
    input  logic [1:0][ADDR_WIDTH-1:0]      addr_i,
    output logic [1:0]                      rdy_o,
    output logic [1:0]                      rvalid_o,
    output logic [CACHELINE_WIDTH-1:0]      rdata_o,
    output logic [ADDR_WIDTH-1:0]           araddr_o,
    output logic [7:0]                      arlen_o,
    output logic [2:0]                      arsize_o,
    output logic [1:0]                      arburst_o,
    output logic                            arvalid_o,
    input  logic                            arready_i,
    input  logic [AXI_DATA_WIDTH-1:0]       rdata_i,
    input  logic                            rvalid_i,
    input  logic                            rlast_i,
    output logic                            rready_o
);
    localparam int BEATS = CACHELINE_WIDTH / AXI_DATA_WIDTH;
    localparam int CNT_W = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] AR   = 2'd1;
    localparam logic [1:0] R    = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    logic [1:0]                 state;
    logic                       winner;
    logic                       pick;
    logic [1:0]                 grant;
    logic [CNT_W-1:0]           beat_cnt;
    logic                       last_beat;
    logic [CACHELINE_WIDTH-1:0] line;
    logic [ADDR_WIDTH-1:0]      addr;
    logic                       unused;

    // Completion is counted in beats; rlast_i is deliberately ignored, and the
    // low address bits are dropped by line alignment.
    assign unused = ^{rlast_i, addr_i[0][3:0], addr_i[1][3:0]};

`ifdef REFILL_ARB_DCACHE_PRIO_EN
    assign pick = rreq_i[1];
`else
    logic last;

    // On a tie the port that was not granted last time wins.
    assign pick = &rreq_i ? ~last : rreq_i[1];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            last <= 1'b1;
        else if (state == IDLE && |rreq_i)
            last <= pick;
`endif

    assign last_beat = beat_cnt == CNT_W'(BEATS - 1);
    assign grant     = winner ? 2'b10 : 2'b01;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            winner   <= 1'b0;
            beat_cnt <= '0;
            line     <= '0;
            addr     <= '0;
        end else begin
            case (state)
                IDLE:
                    if (|rreq_i) begin
                        winner <= pick;
                        addr   <= {addr_i[pick][ADDR_WIDTH-1:4], 4'b0};
                        state  <= AR;
                    end
                AR:
                    if (arready_i)
                        state <= R;
                R:
                    if (rvalid_i) begin
                        line[beat_cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= rdata_i;
                        beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
                        if (last_beat)
                            state <= RESP;
                    end
                RESP:
                    state <= IDLE;
            endcase
        end
    end

    assign arvalid_o = state == AR;
    assign rready_o  = state == R;
    assign rdy_o     = {2{state == AR && arready_i}} & grant;
    // A requester that dropped its request is not told about the drained line.
    assign rvalid_o  = {2{state == RESP}} & grant & rreq_i;
    assign rdata_o   = line;
    assign araddr_o  = addr;
    assign arlen_o   = 8'(BEATS - 1);
    assign arsize_o  = 3'($clog2(AXI_DATA_WIDTH / 8));
    assign arburst_o = 2'b01;
endmodule
